hdc_rule90_hv_generator: RTL and testbench

Parametrised Rule-90 hypervector generator for the HDC sensor-fusion front end. It sits between the feature quantiser and the per-modality spatial encoders. From a single seed it derives a bank of level hypervectors (projm) and a per-channel item-memory hypervector (im) sequence, both with the Rule-90 cellular automaton. It then streams one channel per beat to every modality in lockstep, with back-pressure.

---
 rtl/hdc_pkg.sv | 42 ++++
 rtl/hdc_rule90_step.sv | 19 +
 rtl/hdc_rule90_hv_generator.sv | 147 ++++++++++++++
 tb/tb_hdc_rule90_hv_generator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and helpers for the HDC front end: modality ids, FSM state,
// default channel map and the Rule-90 step on a default-width hypervector.
package hdc_pkg;

    localparam int HV_DIM_DEFAULT = 2000;
    localparam int MAX_MOD        = 4;

    typedef enum logic [1:0] {
        MOD_GSR = 2'd0,
        MOD_ECG = 2'd1,
        MOD_EEG = 2'd2
    } modality_e;

    typedef enum logic [1:0] {
        ST_NOSEED = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // Channel map indexed by modality; entries at or above NUM_MOD are ignored.
    typedef int ch_arr_t [MAX_MOD];
    localparam ch_arr_t CH_DEFAULT = '{32, 77, 105, 0};

    function automatic int ch_at(input int c, input int m, input int n);
        return (m < n) ? c : 0;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [HV_DIM_DEFAULT-1:0] r90(
        input logic [HV_DIM_DEFAULT-1:0] x,
        input bit                        cyclic
    );
        if (cyclic)
            return {x[HV_DIM_DEFAULT-2:0], x[HV_DIM_DEFAULT-1]} ^ {x[0], x[HV_DIM_DEFAULT-1:1]};
        return (x << 1) ^ (x >> 1);
    endfunction

endpackage

// File: rtl/hdc_rule90_step.sv
// One combinational Rule-90 generation: each cell becomes the XOR of its two
// neighbours, with either zero-filled or wrap-around edges.
module hdc_rule90_step #(
    parameter int HV_DIM = 2000,
    parameter bit CYCLIC = 1'b0
) (
    input  logic [HV_DIM-1:0] i_x,
    output logic [HV_DIM-1:0] o_y
);

    generate
        if (CYCLIC) begin : g_cyclic
            assign o_y = {i_x[HV_DIM-2:0], i_x[HV_DIM-1]} ^ {i_x[0], i_x[HV_DIM-1:1]};
        end else begin : g_null
            assign o_y = {i_x[HV_DIM-2:0], 1'b0} ^ {1'b0, i_x[HV_DIM-1:1]};
        end
    endgenerate

endmodule

// File: rtl/hdc_rule90_hv_generator.sv
// Rule-90 level/item hypervector generator: builds a level bank from a seed,
// then streams one channel per beat to all modalities in lockstep.
module hdc_rule90_hv_generator
    import hdc_pkg::*;
#(
    parameter int      HV_DIM     = HV_DIM_DEFAULT,
    parameter int      NUM_MOD    = 3,
    parameter ch_arr_t CH         = CH_DEFAULT,
    parameter int      FEAT_W     = 2,
    parameter int      NUM_LEVELS = 2,
    parameter bit      CYCLIC     = 1'b0,
    localparam int TOTAL_CH = ch_at(CH[0], 0, NUM_MOD) + ch_at(CH[1], 1, NUM_MOD)
                            + ch_at(CH[2], 2, NUM_MOD) + ch_at(CH[3], 3, NUM_MOD),
    localparam int MAX_CH   = imax(imax(ch_at(CH[0], 0, NUM_MOD), ch_at(CH[1], 1, NUM_MOD)),
                                   imax(ch_at(CH[2], 2, NUM_MOD), ch_at(CH[3], 3, NUM_MOD))),
    localparam int CW       = $clog2(MAX_CH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [HV_DIM-1:0]                 seed_hv,
    input  logic                              seed_hv_valid,
    input  logic [TOTAL_CH-1:0][FEAT_W-1:0]   features,
    input  logic                              fin_valid,
    output logic                              fin_ready,
    output logic [HV_DIM-1:0]                 im,
    output logic [NUM_MOD-1:0][HV_DIM-1:0]    projm,
    output logic [NUM_MOD-1:0]                dout_valid,
    input  logic [NUM_MOD-1:0]                dout_ready,
    output logic [CW-1:0]                     chan_idx,
    output logic                              busy
);

    localparam int LW = $clog2(NUM_LEVELS + 1);
    localparam int IW = $clog2(TOTAL_CH);

    state_e                          r_state, w_state_next;
    logic [HV_DIM-1:0]               r_lvl [NUM_LEVELS];
    logic [LW-1:0]                   r_lvl_cnt;
    logic [HV_DIM-1:0]               r_im;
    logic [TOTAL_CH-1:0][FEAT_W-1:0] r_feat;
    logic [CW-1:0]                   r_chan_idx;

    logic              w_fin_fire, w_adv, w_last, w_stream;
    logic [HV_DIM-1:0] w_lvl_tail, w_lvl_step, w_im_src, w_im_step;

    assign w_stream   = (r_state == ST_STREAM);
    assign w_fin_fire = fin_valid && fin_ready && !seed_hv_valid;
    assign w_adv      = &(~dout_valid | dout_ready);
    assign w_last     = (int'(r_chan_idx) == MAX_CH - 1);
    assign im         = r_im;
    assign chan_idx   = r_chan_idx;

    // Level chain extends the most recently written level; im chain starts from LN.
    always_comb begin
        // NOTE: combinational blocks assign a default first so no path leaves a latch.
        w_lvl_tail = '0;
        for (int k = 0; k < NUM_LEVELS; k++)
            if (int'(r_lvl_cnt) == k + 1) w_lvl_tail = r_lvl[k];
    end

    assign w_im_src = w_stream ? r_im : r_lvl[NUM_LEVELS-1];

    hdc_rule90_step #(.HV_DIM(HV_DIM), .CYCLIC(CYCLIC)) u_lvl_step (
        .i_x (w_lvl_tail),
        .o_y (w_lvl_step)
    );

    hdc_rule90_step #(.HV_DIM(HV_DIM), .CYCLIC(CYCLIC)) u_im_step (
        .i_x (w_im_src),
        .o_y (w_im_step)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_NOSEED;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (seed_hv_valid) begin
            w_state_next = (NUM_LEVELS == 1) ? ST_IDLE : ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:   if (int'(r_lvl_cnt) == NUM_LEVELS - 1) w_state_next = ST_IDLE;
                ST_IDLE:   if (w_fin_fire) w_state_next = ST_STREAM;
                ST_STREAM: if (w_adv && w_last) w_state_next = ST_IDLE;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        fin_ready  = (r_state == ST_IDLE);
        busy       = (r_state == ST_INIT) || w_stream;
        dout_valid = '0;
        for (int m = 0; m < NUM_MOD; m++)
            dout_valid[m] = w_stream && (int'(r_chan_idx) < CH[m]);
    end

    for (genvar m = 0; m < NUM_MOD; m++) begin : g_mod
        localparam int BASE = ch_at(CH[0], 0, m) + ch_at(CH[1], 1, m) + ch_at(CH[2], 2, m);

        logic [IW-1:0]     w_idx;
        logic [FEAT_W-1:0] w_code;
        logic [HV_DIM-1:0] w_projm;

        assign w_idx = IW'(BASE + int'(r_chan_idx));

        // Codes 0 and above NUM_LEVELS select nothing; idle modalities output zero.
        always_comb begin
            w_code  = '0;
            w_projm = '0;
            if (dout_valid[m]) w_code = r_feat[w_idx];
            for (int k = 0; k < NUM_LEVELS; k++)
                if (dout_valid[m] && int'(w_code) == k + 1) w_projm = r_lvl[k];
        end

        assign projm[m] = w_projm;
    end

    // NOTE: level bank, im and captured features are pure datapath with no reset;
    // the control state gates every use of them.
    always_ff @(posedge clk) begin
        if (seed_hv_valid) begin
            r_lvl[0]  <= seed_hv;
            r_lvl_cnt <= LW'(1);
        end else if (r_state == ST_INIT) begin
            for (int k = 1; k < NUM_LEVELS; k++)
                if (int'(r_lvl_cnt) == k) r_lvl[k] <= w_lvl_step;
            r_lvl_cnt <= r_lvl_cnt + LW'(1);
        end

        if (w_fin_fire) begin
            r_feat <= features;
            r_im   <= w_im_step;
        end else if (w_stream && w_adv && !seed_hv_valid) begin
            r_im   <= w_im_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || seed_hv_valid)     r_chan_idx <= CW'(MAX_CH);
        else if (w_fin_fire)          r_chan_idx <= '0;
        else if (w_stream && w_adv)   r_chan_idx <= r_chan_idx + CW'(1);
    end

endmodule

// File: tb/tb_hdc_rule90_hv_generator.sv
// Directed bench: D=8, two modalities with 2 and 3 channels, two levels; a
// null-boundary and a cyclic instance share the same stimulus.
module tb_hdc_rule90_hv_generator;

    localparam int D = 8;

    logic            clk;
    logic            rst;
    logic [D-1:0]    seed_hv;
    logic            seed_hv_valid;
    logic [4:0][1:0] features;
    logic            fin_valid;
    logic [1:0]      dout_ready;

    logic            fin_ready,  c_fin_ready;
    logic [D-1:0]    im,         c_im;
    logic [1:0][D-1:0] projm,    c_projm;
    logic [1:0]      dout_valid, c_dout_valid;
    logic [1:0]      chan_idx,   c_chan_idx;
    logic            busy,       c_busy;

    int n_tests = 0;
    int n_fail  = 0;

    hdc_rule90_hv_generator #(
        .HV_DIM(D), .NUM_MOD(2), .CH('{2, 3, 0, 0}), .FEAT_W(2), .NUM_LEVELS(2), .CYCLIC(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .seed_hv(seed_hv), .seed_hv_valid(seed_hv_valid),
        .features(features), .fin_valid(fin_valid), .fin_ready(fin_ready),
        .im(im), .projm(projm), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .chan_idx(chan_idx), .busy(busy)
    );

    hdc_rule90_hv_generator #(
        .HV_DIM(D), .NUM_MOD(2), .CH('{2, 3, 0, 0}), .FEAT_W(2), .NUM_LEVELS(2), .CYCLIC(1'b1)
    ) u_dut_c (
        .clk(clk), .rst(rst), .seed_hv(seed_hv), .seed_hv_valid(seed_hv_valid),
        .features(features), .fin_valid(fin_valid), .fin_ready(c_fin_ready),
        .im(c_im), .projm(c_projm), .dout_valid(c_dout_valid), .dout_ready(dout_ready),
        .chan_idx(c_chan_idx), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_feat(input logic [1:0] a, b, c, d, e);
        features[0] = a; features[1] = b;
        features[2] = c; features[3] = d; features[4] = e;
    endtask

    task automatic load_seed(input logic [D-1:0] s);
        seed_hv = s; seed_hv_valid = 1'b1;
        step();
        seed_hv_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; seed_hv = '0; seed_hv_valid = 1'b0; fin_valid = 1'b0;
        dout_ready = 2'b11; set_feat(1, 2, 2, 0, 3);
        step(); step();
        rst = 1'b0;
        check("rst_fin_ready", fin_ready, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_chan_idx", chan_idx, 3);
        check("rst_projm", projm, 0);

        // Seed 01: one INIT cycle, then IDLE.
        seed_hv = 8'h01; seed_hv_valid = 1'b1;
        step();
        seed_hv_valid = 1'b0;
        check("init_busy", busy, 1);
        check("init_fin_ready", fin_ready, 0);
        step();
        check("idle_fin_ready", fin_ready, 1);
        check("idle_busy", busy, 0);

        // Plain frame {1,2 | 2,0,3}.
        fin_valid = 1'b1;
        step();
        fin_valid = 1'b0;
        check("b0_valid", dout_valid, 2'b11);
        check("b0_chan", chan_idx, 0);
        check("b0_im", im, 8'h05);
        check("b0_projm0", projm[0], 8'h01);
        check("b0_projm1", projm[1], 8'h02);
        check("b0_fin_ready", fin_ready, 0);
        check("b0_busy", busy, 1);
        step();
        check("b1_valid", dout_valid, 2'b11);
        check("b1_im", im, 8'h08);
        check("b1_projm0", projm[0], 8'h02);
        check("b1_projm1", projm[1], 8'h00);
        step();
        check("b2_valid", dout_valid, 2'b10);
        check("b2_chan", chan_idx, 2);
        check("b2_im", im, 8'h14);
        check("b2_projm0", projm[0], 8'h00);
        check("b2_projm1_code3", projm[1], 8'h00);
        step();
        check("end_fin_ready", fin_ready, 1);
        check("end_valid", dout_valid, 0);
        check("end_chan", chan_idx, 3);

        // Stall modality 1 on beat 1 for three cycles.
        fin_valid = 1'b1;
        step();
        fin_valid = 1'b0;
        step();
        check("st_b1_chan", chan_idx, 1);
        dout_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold_chan", chan_idx, 1);
            check("st_hold_im", im, 8'h08);
            check("st_hold_projm0", projm[0], 8'h02);
            check("st_hold_valid", dout_valid, 2'b11);
        end
        dout_ready = 2'b11;
        step();
        check("st_b2_chan", chan_idx, 2);
        check("st_b2_im", im, 8'h14);
        // Modality 0 is idle on beat 2, so its low ready must not stall.
        dout_ready = 2'b10;
        step();
        check("st_end_fin_ready", fin_ready, 1);
        check("st_end_chan", chan_idx, 3);
        dout_ready = 2'b11;

        // New seed aborts the stream on beat 1.
        fin_valid = 1'b1;
        step();
        fin_valid = 1'b0;
        step();
        check("ab_b1_chan", chan_idx, 1);
        seed_hv = 8'h01; seed_hv_valid = 1'b1;
        step();
        seed_hv_valid = 1'b0;
        check("ab_valid", dout_valid, 0);
        check("ab_busy", busy, 1);
        check("ab_fin_ready", fin_ready, 0);
        fin_valid = 1'b1;
        step();
        check("ab_idle_fin_ready", fin_ready, 1);
        check("ab_idle_valid", dout_valid, 0);
        step();
        fin_valid = 1'b0;
        check("ab_new_valid", dout_valid, 2'b11);
        check("ab_new_im", im, 8'h05);
        check("ab_new_projm0", projm[0], 8'h01);
        step(); step(); step();
        check("ab_new_end", fin_ready, 1);

        // Seed and frame in the same cycle: the seed wins.
        fin_valid = 1'b1; seed_hv = 8'h01; seed_hv_valid = 1'b1;
        step();
        fin_valid = 1'b0; seed_hv_valid = 1'b0;
        check("sw_fin_ready", fin_ready, 0);
        check("sw_valid", dout_valid, 0);
        check("sw_busy", busy, 1);
        step();
        check("sw_idle", fin_ready, 1);

        // Boundary modes with seed 80, every channel selecting L2.
        load_seed(8'h80);
        set_feat(2, 2, 2, 2, 2);
        fin_valid = 1'b1;
        step();
        fin_valid = 1'b0;
        check("null_L2", projm[0], 8'h40);
        check("cyc_L2", c_projm[0], 8'h41);
        check("null_im", im, 8'hA0);
        check("cyc_im", c_im, 8'h22);
        check("cyc_L2_m1", c_projm[1], 8'h41);
        step(); step(); step();
        check("cyc_end", fin_ready, 1);

        // Reset mid-stream, then a frame with no fresh seed.
        fin_valid = 1'b1;
        step();
        fin_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", dout_valid, 0);
        check("mrst_chan", chan_idx, 3);
        check("mrst_fin_ready", fin_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_projm", projm, 0);
        fin_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("noseed_fin_ready", fin_ready, 0);
            check("noseed_valid", dout_valid, 0);
        end
        fin_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
